// File: rtl/mem_responder.sv
// mem_responder: fixed-latency, line-organised main-memory responder below the L2 cache.
// Define MEM_RESPONDER_STATS_EN to build the saturating completed-read/write counters.
module mem_responder #(
  parameter int LATENCY = 4,
  parameter int LINE_AW = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         mem_req_valid_i,
  input  logic         mem_req_rw_i,
  input  logic [31:0]  mem_req_addr_i,
  input  logic [127:0] mem_req_data_i,
  output logic [127:0] mem_res_data_o,
  output logic         mem_res_ready_o,
  output logic [31:0]  no_rd_o,
  output logic [31:0]  no_wr_o
);

  localparam int         LINES    = 1 << LINE_AW;
  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [7:0]           r_cnt;
  logic [7:0]           w_cnt_next;
  logic                 w_accept;
  logic                 w_done;
  logic                 r_rw;
  logic [LINE_AW-1:0]   r_idx;
  logic [127:0]         r_wdata;
  logic [127:0]         r_res_data;
  logic [127:0]         r_mem [LINES];
  logic                 w_unused_addr;

  // Offset bits and the aliased upper bits play no part in line selection.
  assign w_unused_addr = ^{mem_req_addr_i[31:LINE_AW+4], mem_req_addr_i[3:0]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mem_req_valid_i) begin
          w_accept     = 1'b1;
          w_cnt_next   = CNT_INIT;
          w_state_next = S_BUSY;
        end
      end
      S_BUSY: begin
        if (r_cnt != 8'd0) begin
          w_cnt_next = r_cnt - 8'd1;
        end else begin
          w_done       = 1'b1;
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // The request is captured once; later changes on mem_req_* are ignored until IDLE.
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_rw    <= mem_req_rw_i;
      r_idx   <= mem_req_addr_i[LINE_AW+3:4];
      r_wdata <= mem_req_data_i;
    end
  end

  // Backing store is never reset; a reset on the commit edge drops the write.
  always_ff @(posedge clk_i) begin
    if (w_done && r_rw && !rst_i) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_res_data <= '0;
    end else if (w_done) begin
      r_res_data <= r_rw ? r_wdata : r_mem[r_idx];
    end
  end

  assign mem_res_data_o  = r_res_data;
  assign mem_res_ready_o = (r_state == S_RESP);

`ifdef MEM_RESPONDER_STATS_EN
  logic [31:0] r_no_rd;
  logic [31:0] r_no_wr;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_no_rd <= '0;
      r_no_wr <= '0;
    end else if (r_state == S_RESP) begin
      if (r_rw) begin
        if (r_no_wr != 32'hFFFF_FFFF) r_no_wr <= r_no_wr + 32'd1;
      end else begin
        if (r_no_rd != 32'hFFFF_FFFF) r_no_rd <= r_no_rd + 32'd1;
      end
    end
  end

  assign no_rd_o = r_no_rd;
  assign no_wr_o = r_no_wr;
`else
  assign no_rd_o = 32'd0;
  assign no_wr_o = 32'd0;
`endif

endmodule
